ov7670_frame_capture: RTL and testbench



---
 rtl/ov7670_pkg.sv | 28 ++
 rtl/ov7670_frame_capture_if.sv | 23 ++
 rtl/ov7670_sync_edge.sv | 41 ++++
 rtl/ov7670_frame_capture.sv | 184 ++++++++++++++++++
 tb/tb_ov7670_frame_capture.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path: geometry defaults, pixel byte
// layout and capture FSM encoding.
package ov7670_pkg;

    localparam int H_ACTIVE_DEF    = 320;
    localparam int V_ACTIVE_DEF    = 240;
    localparam int ADDR_W_DEF      = 17;
    localparam int SKIP_FRAMES_DEF = 2;

    // The camera sends the high byte of each RGB565 word first
    localparam int PIX_HI_MSB = 15;
    localparam int PIX_HI_LSB = 8;
    localparam int PIX_LO_MSB = 7;
    localparam int PIX_LO_LSB = 0;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACTIVE  = 2'd1,
        END     = 2'd2
    } cap_state_e;

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// Camera pins in, frame-buffer write port and frame strobes out.
interface ov7670_frame_capture_if #(
    parameter int ADDR_W = 17
);
    logic              ivsync;
    logic              ihref;
    logic [7:0]        idata;
    logic [15:0]       opixel;
    logic              opixel_valid;
    logic [ADDR_W-1:0] oaddr;
    logic              oframe_done;
    logic              oframe_err;

    modport master (
        input  ivsync, ihref, idata,
        output opixel, opixel_valid, oaddr, oframe_done, oframe_err
    );

    modport slave (
        output ivsync, ihref, idata,
        input  opixel, opixel_valid, oaddr, oframe_done, oframe_err
    );
endinterface

// File: rtl/ov7670_sync_edge.sv
// Registers VSYNC/HREF once and derives single-cycle rise/fall pulses against a
// second register stage.
module ov7670_sync_edge (
    input  logic iclk,
    input  logic irst_n,
    input  logic ivsync,
    input  logic ihref,
    output logic href_q,
    output logic vsync_rise,
    output logic vsync_fall,
    output logic href_rise,
    output logic href_fall
);

    logic vsync_d_r;
    logic vsync_d2_r;
    logic href_d_r;
    logic href_d2_r;

    // Two-deep sample pipeline for both sync lines
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            vsync_d_r  <= 1'b0;
            vsync_d2_r <= 1'b0;
            href_d_r   <= 1'b0;
            href_d2_r  <= 1'b0;
        end else begin
            vsync_d_r  <= ivsync;
            vsync_d2_r <= vsync_d_r;
            href_d_r   <= ihref;
            href_d2_r  <= href_d_r;
        end
    end

    assign href_q     = href_d_r;
    assign vsync_rise = vsync_d_r & ~vsync_d2_r;
    assign vsync_fall = ~vsync_d_r & vsync_d2_r;
    assign href_rise  = href_d_r & ~href_d2_r;
    assign href_fall  = ~href_d_r & href_d2_r;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 capture: pairs camera bytes into RGB565 pixels with frame-buffer
// addresses, drops settling frames and reports complete / short frames.
module ov7670_frame_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
    input  logic                   iclk,
    input  logic                   irst_n,
    ov7670_frame_capture_if.master cam
);

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam int S_W = $clog2(SKIP_FRAMES + 2);
    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE);
    localparam logic [S_W-1:0] S_MAX = S_W'(SKIP_FRAMES);

    logic              href_q_s;
    logic              vsync_rise_s;
    logic              vsync_fall_s;
    logic              href_rise_s;
    logic              href_fall_s;

    cap_state_e        state_r;
    cap_state_e        next_state_s;
    logic [7:0]        data_d_r;
    logic [X_W-1:0]    x_r;
    logic [Y_W-1:0]    y_r;
    logic [S_W-1:0]    skip_cnt_r;
    logic              skip_frame_r;
    logic              phase_r;
    logic [ADDR_W-1:0] addr_cnt_r;
    logic [15:0]       pixel_r;
    logic [ADDR_W-1:0] oaddr_r;
    logic              pixel_valid_r;
    logic              frame_done_r;
    logic              frame_err_r;

    logic              frame_start_s;
    logic              line_end_s;
    logic              capture_s;
    logic              done_s;
    logic              err_s;
    logic              skip_inc_s;
    logic              phase_eff_s;
    logic              emit_s;

    ov7670_sync_edge u_sync_edge (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ivsync     (cam.ivsync),
        .ihref      (cam.ihref),
        .href_q     (href_q_s),
        .vsync_rise (vsync_rise_s),
        .vsync_fall (vsync_fall_s),
        .href_rise  (href_rise_s),
        .href_fall  (href_fall_s)
    );

    // Capture FSM state register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r <= WAIT_VS;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and per-cycle control strobes; a vsync rise also closes an open line
    always_comb begin
        next_state_s  = state_r;
        frame_start_s = 1'b0;
        line_end_s    = 1'b0;
        capture_s     = 1'b0;
        done_s        = 1'b0;
        err_s         = 1'b0;
        skip_inc_s    = 1'b0;
        case (state_r)
            WAIT_VS: begin
                if (vsync_fall_s) begin
                    next_state_s  = ACTIVE;
                    frame_start_s = 1'b1;
                end else begin
                    next_state_s = WAIT_VS;
                end
            end
            ACTIVE: begin
                if (vsync_rise_s) begin
                    next_state_s = END;
                    line_end_s   = 1'b1;
                end else begin
                    capture_s  = href_q_s;
                    line_end_s = href_fall_s;
                end
            end
            END: begin
                next_state_s = WAIT_VS;
                if (skip_frame_r) begin
                    skip_inc_s = (skip_cnt_r < S_MAX);
                end else if (y_r == Y_MAX) begin
                    done_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
            end
            default: begin
                next_state_s = WAIT_VS;
            end
        endcase
    end

    // The first byte after an href rise is always a high byte, whatever phase was left over
    assign phase_eff_s = href_rise_s ? 1'b0 : phase_r;
    assign emit_s      = capture_s & phase_eff_s & (x_r < X_MAX) & (y_r < Y_MAX) & ~skip_frame_r;

    // Byte pairing, position counters, addresses and registered outputs
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            data_d_r      <= 8'd0;
            x_r           <= '0;
            y_r           <= '0;
            skip_cnt_r    <= '0;
            skip_frame_r  <= 1'b0;
            phase_r       <= 1'b0;
            addr_cnt_r    <= '0;
            pixel_r       <= 16'd0;
            oaddr_r       <= '0;
            pixel_valid_r <= 1'b0;
            frame_done_r  <= 1'b1;
            frame_err_r   <= 1'b0;
        end else begin
            data_d_r      <= cam.idata;
            pixel_valid_r <= emit_s;
            frame_done_r  <= ~done_s;
            frame_err_r   <= err_s;
            if (skip_inc_s) begin
                skip_cnt_r <= skip_cnt_r + S_W'(1);
            end
            if (frame_start_s) begin
                x_r          <= '0;
                y_r          <= '0;
                phase_r      <= 1'b0;
                addr_cnt_r   <= '0;
                oaddr_r      <= '0;
                skip_frame_r <= (skip_cnt_r < S_MAX);
            end else if (line_end_s) begin
                phase_r <= 1'b0;
                if (x_r != '0) begin
                    x_r <= '0;
                    if (y_r < Y_MAX) begin
                        y_r <= y_r + Y_W'(1);
                    end
                end
            end else if (capture_s) begin
                if (!phase_eff_s) begin
                    pixel_r[PIX_HI_MSB:PIX_HI_LSB] <= data_d_r;
                    phase_r                        <= 1'b1;
                end else begin
                    pixel_r[PIX_LO_MSB:PIX_LO_LSB] <= data_d_r;
                    phase_r                        <= 1'b0;
                    if (x_r < X_MAX) begin
                        x_r <= x_r + X_W'(1);
                    end
                end
                if (emit_s) begin
                    oaddr_r    <= addr_cnt_r;
                    addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
                end
            end
        end
    end

    assign cam.opixel       = pixel_r;
    assign cam.opixel_valid = pixel_valid_r;
    assign cam.oaddr        = oaddr_r;
    assign cam.oframe_done  = frame_done_r;
    assign cam.oframe_err   = frame_err_r;

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Randomised OV7670 frames against a line/frame-level reference model; a
// monitor compares DUT pixel and frame strobes with the expected queues.
module tb_ov7670_frame_capture;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int AW   = 17;
    localparam int SKIP = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ov7670_frame_capture_if #(.ADDR_W(AW)) bus ();

    ov7670_frame_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .ADDR_W      (AW),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .iclk   (clk),
        .irst_n (rst_n),
        .cam    (bus)
    );

    int checks = 0;
    int passes = 0;
    logic [32:0] pix_q[$];
    int evt_q[$];           // 0 = frame done, 1 = frame error
    int pix_seen = 0;
    int done_seen = 0;
    int err_seen = 0;
    int last_addr = -1;

    // reference model state
    int m_frames = 0;
    bit m_in_frame = 1'b0;
    bit m_skip = 1'b0;
    int m_y = 0;
    int m_addr = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_close();
        if (m_in_frame) begin
            if (!m_skip) evt_q.push_back((m_y == V) ? 0 : 1);
            else if (m_frames < SKIP) m_frames++;
            m_in_frame = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        bus.ivsync = 1'b0;
        m_in_frame = 1'b1;
        m_skip     = (m_frames < SKIP);
        m_y        = 0;
        m_addr     = 0;
        tick(3);
    endtask

    task automatic frame_end();
        @(negedge clk);
        bus.ivsync = 1'b1;
        model_close();
        tick(6);
    endtask

    // n bytes on one href pulse; vs_end raises vsync before href drops
    task automatic send_line(int n, bit pat, bit vs_end);
        logic [7:0] prev;
        logic [7:0] v;
        prev = 8'd0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.ihref = 1'b1;
            v = pat ? (((k % 2) == 0) ? 8'hAB : 8'hCD) : 8'($urandom);
            bus.idata = v;
            if ((k % 2) == 1) begin
                if (m_in_frame && !m_skip && (k / 2) < H && m_y < V) begin
                    pix_q.push_back({17'(m_addr), prev, v});
                    m_addr++;
                end
            end
            prev = v;
        end
        if (m_in_frame && (n / 2) > 0 && m_y < V) m_y++;
        if (vs_end && n > 0) begin
            @(negedge clk);
            bus.ivsync = 1'b1;
            bus.idata  = 8'($urandom);
            model_close();
            @(negedge clk);
            bus.ihref = 1'b0;
            tick(6);
        end else begin
            @(negedge clk);
            bus.ihref = 1'b0;
            tick(3);
        end
    endtask

    task automatic full_frame(int lines, int bytes, bit pat);
        frame_begin();
        for (int l = 0; l < lines; l++) send_line(bytes, pat, 1'b0);
        frame_end();
    endtask

    // monitor: pops expectations whenever the DUT strobes
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (bus.opixel_valid) begin
                pix_seen++;
                if (pix_q.size() == 0) begin
                    checks++;
                    $display("FAIL pix_unexpected: addr %0d data 0x%0h but none expected", bus.oaddr, bus.opixel);
                end else begin
                    e = pix_q.pop_front();
                    chk("pix_addr", 32'(bus.oaddr), 32'(e[32:16]));
                    chk("pix_data", 32'(bus.opixel), 32'(e[15:0]));
                    last_addr = int'(bus.oaddr);
                end
            end
            if (!bus.oframe_done || bus.oframe_err) begin
                if (!bus.oframe_done) done_seen++;
                if (bus.oframe_err) err_seen++;
                if (evt_q.size() == 0) begin
                    checks++;
                    $display("FAIL frame_unexpected: done=%0b err=%0b but no frame end expected", bus.oframe_done, bus.oframe_err);
                end else begin
                    chk("frame_kind", bus.oframe_err ? 32'd1 : 32'd0, 32'(evt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int p0, d0, e0;
        logic [7:0] v;
        bus.ivsync = 1'b1;
        bus.ihref  = 1'b0;
        bus.idata  = 8'd0;
        rst_n      = 1'b0;

        // reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.ivsync = 1'($urandom);
            bus.ihref  = 1'($urandom);
            bus.idata  = 8'($urandom);
            #1;
            chk("rst_done", 32'(bus.oframe_done), 32'd1);
            chk("rst_valid", 32'(bus.opixel_valid), 32'd0);
            chk("rst_addr", 32'(bus.oaddr), 32'd0);
        end
        @(negedge clk);
        bus.ivsync = 1'b1;
        bus.ihref  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // settling frame is discarded
        p0 = pix_seen; d0 = done_seen; e0 = err_seen;
        full_frame(3, 8, 1'b0);
        chk("skip_pixels", 32'(pix_seen - p0), 32'd0);
        chk("skip_strobes", 32'(done_seen + err_seen - d0 - e0), 32'd0);

        // first captured frame with the 0xAB/0xCD pattern
        p0 = pix_seen; d0 = done_seen;
        full_frame(3, 8, 1'b1);
        chk("f2_pixels", 32'(pix_seen - p0), 32'd12);
        chk("f2_done", 32'(done_seen - d0), 32'd1);
        chk("f2_last_addr", 32'(last_addr), 32'd11);

        // over-long line, a zero-pixel href pulse, then normal lines
        p0 = pix_seen; d0 = done_seen;
        frame_begin();
        send_line(11, 1'b0, 1'b0);
        chk("long_line_pixels", 32'(pix_seen - p0), 32'd4);
        send_line(1, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        frame_end();
        chk("f3_pixels", 32'(pix_seen - p0), 32'd12);
        chk("f3_done", 32'(done_seen - d0), 32'd1);

        // short frame
        d0 = done_seen; e0 = err_seen;
        full_frame(2, 8, 1'b0);
        chk("short_err", 32'(err_seen - e0), 32'd1);
        chk("short_no_done", 32'(done_seen - d0), 32'd0);

        // too many lines, the last one closed by vsync while href is high
        p0 = pix_seen; d0 = done_seen;
        frame_begin();
        for (int l = 0; l < 4; l++) send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b1);
        chk("tall_pixels", 32'(pix_seen - p0), 32'd12);
        chk("tall_last_addr", 32'(last_addr), 32'd11);
        chk("tall_done", 32'(done_seen - d0), 32'd1);

        // asynchronous reset in the middle of line 2
        frame_begin();
        send_line(8, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.ihref = 1'b1;
            bus.idata = 8'($urandom);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pixel", 32'(bus.opixel), 32'd0);
        chk("arst_valid", 32'(bus.opixel_valid), 32'd0);
        chk("arst_addr", 32'(bus.oaddr), 32'd0);
        chk("arst_done", 32'(bus.oframe_done), 32'd1);
        chk("arst_err", 32'(bus.oframe_err), 32'd0);
        pix_q.delete();
        evt_q.delete();
        m_in_frame = 1'b0;
        m_frames   = 0;
        @(negedge clk);
        bus.idata = 8'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v = 8'($urandom);
            bus.idata = v;
        end
        @(negedge clk);
        bus.ihref = 1'b0;
        tick(3);
        frame_end();

        p0 = pix_seen; d0 = done_seen;
        full_frame(3, 8, 1'b0);
        chk("post_rst_skip_pixels", 32'(pix_seen - p0), 32'd0);
        chk("post_rst_skip_done", 32'(done_seen - d0), 32'd0);
        p0 = pix_seen; d0 = done_seen;
        full_frame(3, 8, 1'b0);
        chk("post_rst_pixels", 32'(pix_seen - p0), 32'd12);
        chk("post_rst_done", 32'(done_seen - d0), 32'd1);

        // random geometry frames
        for (int f = 0; f < 6; f++) begin
            int nl;
            frame_begin();
            nl = int'($urandom_range(1, 5));
            for (int l = 0; l < nl; l++) send_line(int'($urandom_range(0, 12)), 1'b0, 1'b0);
            frame_end();
        end

        tick(10);
        chk("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        chk("evt_queue_drained", 32'(evt_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
